// File: rtl/alu_seq_pkg.sv
// Shared op codes, state encoding and datapath widths for the ALU op sequencer.
package alu_seq_pkg;

  localparam int NIB_W = 4;
  localparam int ACC_W = 8;

  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_MUL2 = 2'd2;
  localparam logic [1:0] OP_DIV2 = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_step.sv
// Combinational single-step unit: applies one ADD/SUB/MUL2/DIV2 step to the
// accumulator and reports that step's flag.
module alu_step
  import alu_seq_pkg::*;
(
  input  logic [ACC_W-1:0] acc,
  input  logic [NIB_W-1:0] y,
  input  logic [1:0]       op,
  output logic [ACC_W-1:0] next_acc,
  output logic             step_flag
);

  logic [NIB_W:0]   sum;
  logic [NIB_W-1:0] diff;

  assign sum  = {1'b0, acc[NIB_W-1:0]} + {1'b0, y};
  assign diff = acc[NIB_W-1:0] - y;

  always_comb begin
    next_acc  = acc;
    step_flag = 1'b0;
    case (op)
      OP_ADD: begin
        // Upper nibble is forced to zero so ADD/SUB stay in the low nibble.
        next_acc  = {{(ACC_W-NIB_W){1'b0}}, sum[NIB_W-1:0]};
        step_flag = sum[NIB_W];
      end
      OP_SUB: begin
        next_acc  = {{(ACC_W-NIB_W){1'b0}}, diff};
        step_flag = (y > acc[NIB_W-1:0]);
      end
      OP_MUL2: begin
        next_acc  = {acc[ACC_W-2:0], 1'b0};
        step_flag = acc[ACC_W-1];
      end
      default: begin
        next_acc  = {1'b0, acc[ACC_W-1:1]};
        step_flag = acc[0];
      end
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Accepts one command, iterates the chosen ALU step N times (one per clock),
// then holds the accumulated result and sticky flag until consumed.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_x,
  input  logic [3:0]       cmd_y,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [7:0]       res_data,
  output logic             res_flag,
  output logic             busy
);

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [1:0]         op_q, op_d;
  logic [NIB_W-1:0]   y_q, y_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               flag_q, flag_d;

  logic [ACC_W-1:0]   step_acc;
  logic               step_flag;

  alu_step u_step (
    .acc       (acc_q),
    .y         (y_q),
    .op        (op_q),
    .next_acc  (step_acc),
    .step_flag (step_flag)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    op_d    = op_q;
    y_d     = y_q;
    rem_d   = rem_q;
    flag_d  = flag_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d   = cmd_op;
          y_d    = cmd_y;
          flag_d = 1'b0;
          rem_d  = cmd_count;
          // Shift ops work on the full byte {Y,X}; ADD/SUB only on X.
          if (cmd_op == OP_ADD || cmd_op == OP_SUB) begin
            acc_d = {{(ACC_W-NIB_W){1'b0}}, cmd_x};
          end else begin
            acc_d = {cmd_y, cmd_x};
          end
          state_d = (cmd_count != '0) ? S_RUN : S_DONE;
        end
      end
      S_RUN: begin
        acc_d  = step_acc;
        flag_d = flag_q | step_flag;
        rem_d  = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      op_q    <= '0;
      y_q     <= '0;
      rem_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      op_q    <= op_d;
      y_q     <= y_d;
      rem_q   <= rem_d;
      flag_q  <= flag_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign res_data  = acc_q;
  assign res_flag  = flag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: literal per-command expectations plus a
// cycle-level behavioural model checked on every falling edge.
module tb_alu_op_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_x;
  logic [3:0] cmd_y;
  logic [1:0] cmd_op;
  logic [2:0] cmd_count;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_flag;
  logic       busy;

  int tests = 0;
  int fails = 0;

  alu_op_sequencer #(.CNT_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_op    (cmd_op),
    .cmd_count (cmd_count),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_flag  (res_flag),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Final result of N steps computed with plain integer arithmetic.
  function automatic void model_result(input int x, input int y, input int op, input int n,
                                       output int d, output bit f);
    int a;
    a = (op < 2) ? x : (y * 16 + x);
    f = 1'b0;
    for (int i = 0; i < n; i++) begin
      case (op)
        0: begin a = a + y; if (a >= 16) begin f = 1'b1; a = a - 16; end end
        1: begin if (y > a) f = 1'b1; a = (a - y + 16) % 16; end
        2: begin if (a >= 128) f = 1'b1; a = (a * 2) % 256; end
        default: begin if (a % 2 == 1) f = 1'b1; a = a / 2; end
      endcase
    end
    d = a;
  endfunction

  // Model phase: 0 idle, 1 computing, 2 result held.
  int m_phase = 0;
  int m_left  = 0;
  int m_data  = 0;
  bit m_flag  = 1'b0;
  bit m_live  = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_data = 0; m_flag = 1'b0; m_left = 0; m_live = 1'b1;
    end else begin
      case (m_phase)
        0: if (cmd_valid) begin
             model_result(int'(cmd_x), int'(cmd_y), int'(cmd_op), int'(cmd_count), m_data, m_flag);
             m_left  = int'(cmd_count);
             m_phase = (m_left == 0) ? 2 : 1;
           end
        1: begin m_left--; if (m_left == 0) m_phase = 2; end
        default: if (res_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_cmd_ready", {31'd0, cmd_ready}, {31'd0, m_phase == 0});
      check("model_res_valid", {31'd0, res_valid}, {31'd0, m_phase == 2});
      check("model_busy",      {31'd0, busy},      {31'd0, m_phase != 0});
      if (m_phase != 1) begin
        check("model_res_data", {24'd0, res_data}, m_data);
        check("model_res_flag", {31'd0, res_flag}, {31'd0, m_flag});
      end
    end
  end

  // Issue one command with res_ready=1 and check latency/result against literals.
  task automatic run_cmd(input string name, input logic [3:0] x, input logic [3:0] y,
                         input logic [1:0] op, input logic [2:0] n,
                         input logic [7:0] exp_d, input logic exp_f);
    int lat;
    check({name, "_ready"}, {31'd0, cmd_ready}, 32'd1);
    cmd_x = x; cmd_y = y; cmd_op = op; cmd_count = n;
    cmd_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_x = ~x; cmd_y = ~y; cmd_op = op + 2'd1; cmd_count = n + 3'd1;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"},  lat, int'(n));
    check({name, "_data"}, {24'd0, res_data}, {24'd0, exp_d});
    check({name, "_flag"}, {31'd0, res_flag}, {31'd0, exp_f});
    $display("[TB] %s x=%0h y=%0h op=%0d n=%0d -> data=%02h flag=%0b lat=%0d",
             name, x, y, op, n, res_data, res_flag, lat);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1; cmd_valid = 1'b0; cmd_x = '0; cmd_y = '0; cmd_op = '0;
    cmd_count = '0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("rst_res_valid", {31'd0, res_valid}, 32'd0);
    check("rst_res_data",  {24'd0, res_data},  32'd0);
    check("rst_res_flag",  {31'd0, res_flag},  32'd0);
    check("rst_busy",      {31'd0, busy},      32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_cmd("add3",    4'h3, 4'h5, 2'd0, 3'd3, 8'h02, 1'b1);
    run_cmd("sub4",    4'h9, 4'h2, 2'd1, 3'd4, 8'h01, 1'b0);
    run_cmd("sub5",    4'h9, 4'h2, 2'd1, 3'd5, 8'h0F, 1'b1);
    run_cmd("mul2_1",  4'h1, 4'h8, 2'd2, 3'd1, 8'h02, 1'b1);
    run_cmd("div2_3",  4'h4, 4'hB, 2'd3, 3'd3, 8'h16, 1'b1);
    run_cmd("div2_2",  4'h4, 4'hB, 2'd3, 3'd2, 8'h2D, 1'b0);
    run_cmd("add0",    4'h7, 4'h6, 2'd0, 3'd0, 8'h07, 1'b0);
    run_cmd("mul2_0",  4'h1, 4'h8, 2'd2, 3'd0, 8'h81, 1'b0);
    run_cmd("add7",    4'h0, 4'h1, 2'd0, 3'd7, 8'h07, 1'b0);
    run_cmd("mul2_7",  4'h1, 4'h0, 2'd2, 3'd7, 8'h80, 1'b0);

    // Backpressure: result held while a second command is presented.
    cmd_x = 4'h7; cmd_y = 4'h6; cmd_op = 2'd0; cmd_count = 3'd2;
    cmd_valid = 1'b1; res_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_x = 4'h2; cmd_y = 4'h3; cmd_op = 2'd1; cmd_count = 3'd1;
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_lat", lat, 32'd2);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold_valid", {31'd0, res_valid}, 32'd1);
      check("bp_hold_ready", {31'd0, cmd_ready}, 32'd0);
      check("bp_hold_data",  {24'd0, res_data},  32'h03);
      check("bp_hold_flag",  {31'd0, res_flag},  32'd1);
    end
    $display("[TB] backpressure first result data=%02h flag=%0b held 5 cycles", res_data, res_flag);
    res_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    check("bp_idle_valid", {31'd0, res_valid}, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_second_busy", {31'd0, busy}, 32'd1);
    lat = 0;
    while (res_valid !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_second_lat",  lat, 32'd1);
    check("bp_second_data", {24'd0, res_data}, 32'h0F);
    check("bp_second_flag", {31'd0, res_flag}, 32'd1);
    $display("[TB] backpressure second result data=%02h flag=%0b lat=%0d", res_data, res_flag, lat);
    @(negedge clk);

    // Reset in the middle of a long run aborts it.
    cmd_x = 4'h3; cmd_y = 4'h5; cmd_op = 2'd0; cmd_count = 3'd7;
    cmd_valid = 1'b1; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    check("abort_res_valid", {31'd0, res_valid}, 32'd0);
    check("abort_res_data",  {24'd0, res_data},  32'd0);
    check("abort_res_flag",  {31'd0, res_flag},  32'd0);
    check("abort_busy",      {31'd0, busy},      32'd0);
    $display("[TB] reset during run: data=%02h busy=%0b", res_data, busy);
    reset = 1'b0;
    @(negedge clk);
    run_cmd("after_rst", 4'h3, 4'h5, 2'd0, 3'd3, 8'h02, 1'b1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequences the 4-bit arithmetic datapath (add, subtract, multiply-by-2, divide-by-2).
- Accepts one command at a time over a valid/ready handshake and applies the selected operation iteratively, 0..2^CNT_W-1 times, one step per clock.
- Presents the final result and a sticky status flag over a valid/ready handshake.
- Sits between the switch/button front end and the display/LED logic.

Parameters:
CNT_W, 3, width of the iteration count (maximum 2^CNT_W-1 steps)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_x  input  4  operand X
cmd_y  input  4  operand Y
cmd_op  input  2  0=ADD, 1=SUB, 2=MUL2, 3=DIV2
cmd_count  input  CNT_W  number of steps N
res_valid  output  1  result held and valid
res_ready  input  1  consumer takes result
res_data  output  8  accumulated result
res_flag  output  1  OR of all per-step flags
busy  output  1  high in RUN or DONE

Behaviour:
- One clock (clk), synchronous active-high reset (reset).
- Reset values:
  - state=IDLE
  - cmd_ready=1
  - res_valid=0
  - res_data=8'h00
  - res_flag=0
  - busy=0
  - internal accumulator, op and remaining-count registers all 0.
- States:
  - IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op and Y, load the accumulator and clear the flag.
    - Accumulator load for ADD/SUB: {4'h0,X}. For MUL2/DIV2: {Y,X}.
    - Next state: remaining=N and state=RUN if N>0; state=DONE if N=0.
  - RUN: each cycle apply one step, set flag|=step_flag, decrement remaining. The step taken with remaining=1 moves to DONE.
  - DONE: res_valid=1. res_data and res_flag are stable while res_ready=0. On res_ready, go to IDLE next cycle with res_valid=0.
- Step semantics:
  - ADD: acc[3:0]=acc[3:0]+Y mod 16; step_flag=carry-out; acc[7:4] stays 0.
  - SUB: acc[3:0]=acc[3:0]-Y mod 16 (two's-complement wrap); step_flag=(Y>acc[3:0]) evaluated before the step.
  - MUL2: acc=acc<<1 (8-bit, bit 0 filled with 0); step_flag=acc[7] before the shift.
  - DIV2: acc=acc>>1 (logical); step_flag=acc[0] before the shift.
- Latency: for acceptance on edge E, res_valid rises after edge E+N (N=0 means it is visible right after E).
- res_data is the accumulator; res_flag is the sticky flag. Both outputs are registered.
- cmd_ready=0 in RUN and DONE. cmd_valid is ignored there, with no queueing.
- In DONE, res_ready and cmd_valid in the same cycle: the result is consumed and the command is not accepted. Acceptance happens at the earliest on the following cycle in IDLE.
- cmd_* values are sampled only at acceptance; later changes have no effect.
- reset has priority over every transition. Reset in RUN or DONE aborts to IDLE with all outputs at their reset values on the next cycle, and no result is produced.
- Count wrap: N is unsigned. N=2^CNT_W-1 runs the full count; no modulo behaviour beyond the register width.

Decomposition:
- Shared package alu_seq_pkg holds:
  - op codes OP_ADD=2'd0, OP_SUB=2'd1, OP_MUL2=2'd2, OP_DIV2=2'd3
  - state encoding S_IDLE, S_RUN, S_DONE
  - data widths NIB_W=4 and ACC_W=8
- Sub-module alu_step: purely combinational one-step unit. Inputs acc[7:0], y[3:0], op[1:0]; outputs next_acc[7:0], step_flag. The sequencer holds all registers and the FSM.

Test Plan:
- ADD X=3,Y=5,N=3, res_ready=1 -> res_valid 3 cycles after acceptance, res_data=8'h02 (8,13,18 mod 16), res_flag=1.
- SUB X=9,Y=2,N=4 -> res_data=8'h01, res_flag=0. Repeat with N=5 -> res_data=8'h0F, res_flag=1.
- MUL2 X=1,Y=8 (acc 8'h81),N=1 -> res_data=8'h02, res_flag=1. DIV2 X=4,Y=B (8'hB4),N=3 -> res_data=8'h16, res_flag=1. DIV2 8'hB4,N=2 -> 8'h2D, res_flag=0.
- N=0 ADD X=7,Y=6 -> res_valid after the acceptance edge, res_data=8'h07, res_flag=0. N=0 MUL2 X=1,Y=8 -> res_data=8'h81.
- Backpressure: hold res_ready=0 for 5 cycles in DONE while driving a new cmd_valid -> res_data/res_flag stable, cmd_ready=0, no acceptance. res_ready=1 then returns to IDLE, and the second command is accepted on the next cycle.
- Assert reset during RUN of ADD N=7 -> next cycle state IDLE, cmd_ready=1, res_valid=0, res_data=8'h00, res_flag=0. A following command runs correctly.
